imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
// Instruction-memory responder: the memory-side end of the fetch stage's imem_addr_F interface.
// Accepts one fetch request at a time, waits a fixed number of wait-states, then returns the
// 32-bit LEGv8 instruction word held under a valid/ready handshake. Misaligned or out-of-range
// addresses return a NOP with a fault flag. A write port preloads program contents for test.
// PARAMETERS
// ADDR_W      64           fetch address width (matches PC width)
// MEM_WORDS   64           number of 32-bit instruction words; power of 2, >= 2
// WAIT_CYCLES 1            wait-states between request accept and response; 0..15
// NOP_INSTR   32'hD503201F word returned on fault
// PORTS
// clk          in  1               clock, rising edge
// reset        in  1               synchronous, active-high
// req_valid_F  in  1               fetch request valid
// req_ready_F  out 1               responder can accept a request
// imem_addr_F  in  ADDR_W          byte address of the requested instruction
// rsp_valid_F  out 1               instr_F/fault_F valid
// rsp_ready_F  in  1               fetch stage consumes the response
// instr_F      out 32              instruction word
// fault_F      out 1               1 = misaligned or out-of-range request
// prog_we      in  1               program-load write enable
// prog_addr    in  $clog2(MEM_WORDS) word index for the program write
// prog_data    in  32              program word
// BEHAVIOUR
// - Reset: state IDLE, req_ready_F=1, rsp_valid_F=0, instr_F=0, fault_F=0, wait counter=0.
//   Memory contents are not cleared. Reset mid-request drops the request; no response is issued.
// - FSM IDLE -> WAIT -> RESP -> IDLE. req_ready_F=1 only in IDLE; rsp_valid_F=1 only in RESP.
// - IDLE: on req_valid_F & req_ready_F, capture imem_addr_F. If WAIT_CYCLES=0, go to RESP;
//   otherwise load the counter with WAIT_CYCLES and go to WAIT.
// - WAIT: decrement the counter each cycle; on the cycle the counter is 1, go to RESP.
// - Latency: rsp_valid_F rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
// - Read: the memory word is sampled on the edge entering RESP (word index = addr[2+:log2 MEM_WORDS]).
// - RESP: instr_F and fault_F are registered and stay stable while rsp_valid_F=1 and
//   rsp_ready_F=0. On rsp_valid_F & rsp_ready_F, go to IDLE on that edge. Earliest next accept
//   is the following cycle; the request-to-request interval is >= WAIT_CYCLES+2 cycles.
// - Fault: addr[1:0] != 0 (misaligned) or (addr >> 2) >= MEM_WORDS (out of range). On fault,
//   fault_F=1 and instr_F=NOP_INSTR, with the same latency and handshake as a normal response.
// - Address comparison uses the full ADDR_W bits; high bits are never truncated.
// - prog_we: writes prog_data to mem[prog_addr] on any edge and in any state.
//   If the write hits the word being sampled on the same edge, the read returns the old data
//   (read-before-write).
// - req_valid_F outside IDLE is ignored. Requests are not queued.
// TESTING
// 1. Preload mem[0..3]=11,22,33,44; WAIT_CYCLES=1; request addr 0x8 -> rsp_valid_F at accept+2, instr_F=33, fault_F=0.
// 2. Request addr 0x6 -> fault_F=1, instr_F=D503201F; request addr 0x100 (MEM_WORDS=64) -> fault_F=1.
// 3. Hold rsp_ready_F=0 for 5 cycles -> instr_F/rsp_valid_F stable and req_ready_F=0; release -> IDLE on the next edge.
// 4. Assert reset while in WAIT -> next cycle req_ready_F=1, rsp_valid_F=0; no stale response appears afterwards.
// 5. WAIT_CYCLES=0: request addr 0x4 -> rsp_valid_F the cycle after accept; with rsp_ready_F held high, accepts occur every 2 cycles.
// 6. prog_we to word 2 on the edge entering RESP for addr 0x8 -> old word returned; a repeat fetch returns the new word.

Source files
------------

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
// Memory-side end of the fetch stage's instruction interface. It accepts one
// fetch request at a time and waits WAIT_CYCLES wait-states. It then holds the
// 32-bit instruction word under a valid/ready handshake until the fetch stage
// takes it. Misaligned or out-of-range addresses return NOP_INSTR with
// fault_F set. A separate write port preloads program contents.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   req_valid_F  in   fetch request valid
//   req_ready_F  out  responder can accept a request (IDLE only)
//   imem_addr_F  in   byte address of the requested instruction
//   rsp_valid_F  out  instr_F / fault_F valid (RESP only)
//   rsp_ready_F  in   fetch stage consumes the response
//   instr_F      out  instruction word
//   fault_F      out  1 = misaligned or out-of-range request
//   prog_we      in   program-load write enable
//   prog_addr    in   word index for the program write
//   prog_data    in   program word
// ---------------------------------------------------------------------------
module imem_responder #(
   parameter int          ADDR_W      = 64,
   parameter int          MEM_WORDS   = 64,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] NOP_INSTR   = 32'hD503201F
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid_F,
   output logic                         req_ready_F,
   input  logic [ADDR_W-1:0]            imem_addr_F,
   output logic                         rsp_valid_F,
   input  logic                         rsp_ready_F,
   output logic [31:0]                  instr_F,
   output logic                         fault_F,
   input  logic                         prog_we,
   input  logic [$clog2(MEM_WORDS)-1:0] prog_addr,
   input  logic [31:0]                  prog_data
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       mem [MEM_WORDS];

   logic [ADDR_W-1:0] rd_addr;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_fault;

   // Address used for the read and the fault check. With zero wait-states the
   // word is sampled on the accepting edge, so the live request address is
   // used there. Otherwise the captured address is used.
   always_comb begin
      rd_addr  = (state == S_IDLE) ? imem_addr_F : addr_q;
      rd_idx   = rd_addr[2 +: IDX_W];
      // The full address width is compared so that high bits can never alias
      // into a valid word.
      rd_fault = (rd_addr[1:0] != 2'b00) ||
                 ((rd_addr >> 2) >= ADDR_W'(MEM_WORDS));
   end

   // Program-load port. It has no reset and is not gated by the FSM. The
   // response register reads mem with a non-blocking sample on the same edge,
   // so a colliding write returns the old word.
   always_ff @(posedge clk) begin
      if (prog_we)
         mem[prog_addr] <= prog_data;
   end

   // Request FSM: IDLE -> WAIT -> RESP -> IDLE. The handshake outputs are
   // registered alongside the state. The response word is captured on the
   // edge entering RESP and held until the fetch stage takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         req_ready_F <= 1'b1;
         rsp_valid_F <= 1'b0;
         instr_F     <= 32'd0;
         fault_F     <= 1'b0;
         wait_cnt    <= 4'd0;
         addr_q      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid_F && req_ready_F) begin
                  addr_q      <= imem_addr_F;
                  req_ready_F <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state       <= S_RESP;
                     rsp_valid_F <= 1'b1;
                     fault_F     <= rd_fault;
                     instr_F     <= rd_fault ? NOP_INSTR : mem[rd_idx];
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= 4'(WAIT_CYCLES);
                  end
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state       <= S_RESP;
                  rsp_valid_F <= 1'b1;
                  fault_F     <= rd_fault;
                  instr_F     <= rd_fault ? NOP_INSTR : mem[rd_idx];
               end
            end
            S_RESP: begin
               if (rsp_ready_F) begin
                  state       <= S_IDLE;
                  rsp_valid_F <= 1'b0;
                  req_ready_F <= 1'b1;
               end
            end
            default: begin
               state       <= S_IDLE;
               req_ready_F <= 1'b1;
               rsp_valid_F <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
// Directed bench for imem_responder. It drives one instance with one
// wait-state and one instance with zero wait-states. The two instances share
// the clock, the reset and the program-load port.
// ---------------------------------------------------------------------------
module tb_imem_responder;

   localparam logic [31:0] NOP = 32'hD503201F;

   logic        clk = 1'b0;
   logic        reset;
   logic        prog_we;
   logic [5:0]  prog_addr;
   logic [31:0] prog_data;

   logic        req_valid_F, req_ready_F, rsp_valid_F, rsp_ready_F, fault_F;
   logic [63:0] imem_addr_F;
   logic [31:0] instr_F;

   logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, fault0;
   logic [63:0] addr0;
   logic [31:0] instr0;

   int total = 0;
   int bad   = 0;

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   imem_responder #(.ADDR_W(64), .MEM_WORDS(64), .WAIT_CYCLES(1)) dut (
      .clk(clk), .reset(reset),
      .req_valid_F(req_valid_F), .req_ready_F(req_ready_F), .imem_addr_F(imem_addr_F),
      .rsp_valid_F(rsp_valid_F), .rsp_ready_F(rsp_ready_F),
      .instr_F(instr_F), .fault_F(fault_F),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
   );

   imem_responder #(.ADDR_W(64), .MEM_WORDS(64), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid_F(req0_valid), .req_ready_F(req0_ready), .imem_addr_F(addr0),
      .rsp_valid_F(rsp0_valid), .rsp_ready_F(rsp0_ready),
      .instr_F(instr0), .fault_F(fault0),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
   );

   // Advance one clock. Inputs are driven and outputs are sampled 1 ns after
   // the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every comparison goes through this task. It counts the comparison and
   // reports a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Runs one fetch through the one-wait-state instance. The response is
   // checked at accept+1 (not yet valid) and at accept+2 (valid). It is then
   // consumed, and the return to IDLE is checked.
   task automatic applyStimulus(input string tag, input logic [63:0] addr,
                                input logic [31:0] exp_instr, input logic exp_fault);
      req_valid_F = 1'b1;
      imem_addr_F = addr;
      step();
      req_valid_F = 1'b0;
      checkOutput({tag, "_busy"}, {63'd0, rsp_valid_F}, 64'd0);
      step();
      checkOutput({tag, "_valid"}, {63'd0, rsp_valid_F}, 64'd1);
      checkOutput({tag, "_instr"}, {32'd0, instr_F}, {32'd0, exp_instr});
      checkOutput({tag, "_fault"}, {63'd0, fault_F}, {63'd0, exp_fault});
      rsp_ready_F = 1'b1;
      step();
      rsp_ready_F = 1'b0;
      checkOutput({tag, "_idle_rdy"}, {63'd0, req_ready_F}, 64'd1);
      checkOutput({tag, "_idle_vld"}, {63'd0, rsp_valid_F}, 64'd0);
   endtask

   // Directed test sequence.
   initial begin
      logic [31:0] preload [4];
      preload = '{32'd11, 32'd22, 32'd33, 32'd44};

      reset = 1'b1;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      req_valid_F = 1'b0; imem_addr_F = '0; rsp_ready_F = 1'b0;
      req0_valid = 1'b0; addr0 = '0; rsp0_ready = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state of both instances.
      checkOutput("rst_req_ready", {63'd0, req_ready_F}, 64'd1);
      checkOutput("rst_rsp_valid", {63'd0, rsp_valid_F}, 64'd0);
      checkOutput("rst_instr",     {32'd0, instr_F},     64'd0);
      checkOutput("rst_fault",     {63'd0, fault_F},     64'd0);
      checkOutput("rst0_req_ready", {63'd0, req0_ready}, 64'd1);
      checkOutput("rst0_rsp_valid", {63'd0, rsp0_valid}, 64'd0);

      // Preload words 0..3 and the last word (63).
      for (int i = 0; i < 4; i++) begin
         prog_we = 1'b1; prog_addr = 6'(i); prog_data = preload[i];
         step();
      end
      prog_addr = 6'd63; prog_data = 32'hABCD1234;
      step();
      prog_we = 1'b0;

      // Test 1: basic fetch with one wait-state. The response is held for
      // five cycles with rsp_ready low.
      req_valid_F = 1'b1;
      imem_addr_F = 64'h8;
      step();
      req_valid_F = 1'b0;
      checkOutput("t1_accept_plus1", {63'd0, rsp_valid_F}, 64'd0);
      step();
      checkOutput("t1_valid", {63'd0, rsp_valid_F}, 64'd1);
      checkOutput("t1_instr", {32'd0, instr_F},     64'd33);
      checkOutput("t1_fault", {63'd0, fault_F},     64'd0);
      // A request presented outside IDLE must be ignored.
      req_valid_F = 1'b1;
      imem_addr_F = 64'h0;
      for (int k = 0; k < 5; k++) begin
         step();
         checkOutput("t3_hold_valid", {63'd0, rsp_valid_F}, 64'd1);
         checkOutput("t3_hold_instr", {32'd0, instr_F},     64'd33);
         checkOutput("t3_hold_ready", {63'd0, req_ready_F}, 64'd0);
      end
      req_valid_F = 1'b0;
      rsp_ready_F = 1'b1;
      step();
      rsp_ready_F = 1'b0;
      checkOutput("t3_release_valid", {63'd0, rsp_valid_F}, 64'd0);
      checkOutput("t3_release_ready", {63'd0, req_ready_F}, 64'd1);

      // Test 2: fault cases and range boundaries.
      applyStimulus("t2_misalign", 64'h6, NOP, 1'b1);
      applyStimulus("t2_oor", 64'h100, NOP, 1'b1);
      applyStimulus("t2_highbit", 64'h1_0000_0008, NOP, 1'b1);
      applyStimulus("t2_lastword", 64'hFC, 32'hABCD1234, 1'b0);
      applyStimulus("t2_word0", 64'h0, 32'd11, 1'b0);

      // Test 4: reset while in WAIT drops the request.
      req_valid_F = 1'b1;
      imem_addr_F = 64'hC;
      step();
      req_valid_F = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("t4_ready", {63'd0, req_ready_F}, 64'd1);
      checkOutput("t4_valid", {63'd0, rsp_valid_F}, 64'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         checkOutput("t4_no_stale", {63'd0, rsp_valid_F}, 64'd0);
      end

      // Test 5: zero wait-states, with request and rsp_ready held high. The
      // instance should accept on every other edge.
      req0_valid = 1'b1;
      addr0      = 64'h4;
      rsp0_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         checkOutput("t5_valid", {63'd0, rsp0_valid}, {63'd0, (k % 2) == 0});
         checkOutput("t5_ready", {63'd0, req0_ready}, {63'd0, (k % 2) == 1});
         if ((k % 2) == 0) begin
            checkOutput("t5_instr", {32'd0, instr0}, 64'd22);
            checkOutput("t5_fault", {63'd0, fault0}, 64'd0);
         end
      end
      req0_valid = 1'b0;
      rsp0_ready = 1'b0;
      step();

      // Test 6: a write to word 2 on the edge entering RESP returns the old
      // word. A repeat fetch then returns the new word.
      req_valid_F = 1'b1;
      imem_addr_F = 64'h8;
      step();
      req_valid_F = 1'b0;
      prog_we = 1'b1; prog_addr = 6'd2; prog_data = 32'h55AA55AA;
      step();
      prog_we = 1'b0;
      checkOutput("t6_old_valid", {63'd0, rsp_valid_F}, 64'd1);
      checkOutput("t6_old_instr", {32'd0, instr_F},     64'd33);
      rsp_ready_F = 1'b1;
      step();
      rsp_ready_F = 1'b0;
      applyStimulus("t6_new", 64'h8, 32'h55AA55AA, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
